// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, limits and ROM contents for the instruction fetch unit
package imem_pkg;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        MISALIGNED = 2'd1,
        UNMAPPED   = 2'd2
    } fetch_fault_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROM_RD   = 3'd1,
        RAM_WAIT = 3'd2,
        RESP     = 3'd3,
        LOAD     = 3'd4
    } imem_state_e;

    localparam int RAM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(RAM_LAT_MAX + 1);

    // Fixed ROM image: tag in the upper half, word index in the lower half.
    function automatic logic [31:0] rom_word(input logic [15:0] waddr);
        return {16'hC0DE, waddr};
    endfunction

endpackage

// File: rtl/imem_ram_pipe.sv
// rtl/imem_ram_pipe.sv - single-port program RAM with a stallable RAM_LAT-deep read pipeline
module imem_ram_pipe #(
    parameter int DATA_W  = 32,
    parameter int RAM_AW  = 20,
    parameter int RAM_LAT = 1
) (
    input  logic              clka,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_advance,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**RAM_AW];
    logic [DATA_W-1:0] pipe [RAM_LAT];

    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The pipe only moves when the fetch FSM asks, so a held response stays put.
    always_ff @(posedge clka) begin
        if (rd_advance) begin
            pipe[0] <= mem[rd_addr];
            for (int i = 1; i < RAM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_data = pipe[RAM_LAT-1];

endmodule

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction memory front end: ROM/RAM decode, handshake, flush and load port
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE = 'h0000_0000,
    parameter int                ROM_AW   = 14,
    parameter logic [ADDR_W-1:0] RAM_BASE = 'h0001_0000,
    parameter int                RAM_AW   = 20,
    parameter int                RAM_LAT  = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] PC,
    input  logic              PC_Changed,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [1:0]        RSP_FAULT,
    input  logic              TB_LOAD_PROGRAM_CTRL,
    input  logic [DATA_W-1:0] TB_LOAD_PROGRAM_DATA,
    input  logic [RAM_AW-1:0] TB_LOAD_PROGRAM_ADDR,
    output logic              TB_LOAD_READY,
    output logic              I_FSM_STALL_FETCH
);

    localparam logic [ADDR_W:0]    ROM_SIZE = (ADDR_W+1)'(1) << (ROM_AW + 2);
    localparam logic [ADDR_W:0]    RAM_SIZE = (ADDR_W+1)'(1) << (RAM_AW + 2);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(RAM_LAT - 1);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fetch_fault_e      fault_q, fault_d;
    logic              src_ram_q, src_ram_d;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] ram_rd_data;

    logic              req_ready;
    logic              accept;
    logic              rsp_valid;
    logic              misaligned, in_rom, in_ram;
    logic              rom_hit, ram_hit;
    logic [ADDR_W-1:0] rom_off, ram_off;
    logic [ROM_AW-1:0] rom_waddr;
    logic [RAM_AW-1:0] ram_waddr;
    logic              ram_advance;
    logic              ram_wr;

    // Offsets wrap when PC is below a base, hence the explicit lower-bound compare.
    assign rom_off    = PC - ROM_BASE;
    assign ram_off    = PC - RAM_BASE;
    assign misaligned = |PC[1:0];
    assign in_rom     = (PC >= ROM_BASE) && ({1'b0, rom_off} < ROM_SIZE);
    assign in_ram     = (PC >= RAM_BASE) && ({1'b0, ram_off} < RAM_SIZE);
    assign rom_hit    = !misaligned && in_rom;
    assign ram_hit    = !misaligned && !in_rom && in_ram;
    assign rom_waddr  = rom_off[ROM_AW+1:2];
    assign ram_waddr  = ram_off[RAM_AW+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        src_ram_d = src_ram_q;
        req_ready = 1'b0;

        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (TB_LOAD_PROGRAM_CTRL) begin
                        state_d = LOAD;
                    end else begin
                        req_ready = 1'b1;
                    end
                end
                ROM_RD, RESP: begin
                    if (PC_Changed) begin
                        state_d = IDLE;
                    end else if (RSP_READY) begin
                        state_d   = IDLE;
                        req_ready = !TB_LOAD_PROGRAM_CTRL;
                    end else begin
                        state_d = RESP;
                    end
                end
                RAM_WAIT: begin
                    if (PC_Changed) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = RESP;
                        end
                    end
                end
                LOAD: begin
                    if (!TB_LOAD_PROGRAM_CTRL) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A newly accepted request overrides whatever the current state chose.
            if (req_ready && REQ_VALID) begin
                src_ram_d = 1'b0;
                cnt_d     = '0;
                if (misaligned) begin
                    fault_d = MISALIGNED;
                    state_d = ROM_RD;
                end else if (in_rom) begin
                    fault_d = OK;
                    state_d = ROM_RD;
                end else if (in_ram) begin
                    fault_d   = OK;
                    src_ram_d = 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = (RAM_LAT == 1) ? RESP : RAM_WAIT;
                end else begin
                    fault_d = UNMAPPED;
                    state_d = ROM_RD;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fault_q   <= OK;
            src_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            src_ram_q <= src_ram_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && rom_hit) begin
            rom_q <= DATA_W'(rom_word(16'(rom_waddr)));
        end
    end

    assign accept      = req_ready && REQ_VALID;
    assign ram_advance = EN && ((accept && ram_hit) || (state_q == RAM_WAIT));
    assign ram_wr      = EN && (state_q == LOAD) && TB_LOAD_PROGRAM_CTRL;

    imem_ram_pipe #(
        .DATA_W  (DATA_W),
        .RAM_AW  (RAM_AW),
        .RAM_LAT (RAM_LAT)
    ) u_ram (
        .clka       (CLK),
        .wr_en      (ram_wr),
        .wr_addr    (TB_LOAD_PROGRAM_ADDR),
        .wr_data    (TB_LOAD_PROGRAM_DATA),
        .rd_advance (ram_advance),
        .rd_addr    (ram_waddr),
        .rd_data    (ram_rd_data)
    );

    // ROM_RD presents the one-cycle ROM/fault response; RESP holds any response.
    assign rsp_valid         = (state_q == ROM_RD) || (state_q == RESP);
    assign RSP_VALID         = rsp_valid;
    assign RSP_FAULT         = rsp_valid ? fault_q : OK;
    assign RSP_DATA          = (rsp_valid && fault_q == OK) ? (src_ram_q ? ram_rd_data : rom_q) : '0;
    assign REQ_READY         = RSTn && req_ready;
    assign TB_LOAD_READY     = EN && (state_q == LOAD);
    assign I_FSM_STALL_FETCH = (state_q == ROM_RD) || (state_q == RAM_WAIT) || (state_q == LOAD);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed and randomized checks of imem_fetch_unit against a memory-map model
module tb_imem_fetch_unit;

    localparam int LAT_RAM = 3;

    logic        CLK;
    logic        RSTn;
    logic        EN;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [31:0] PC;
    logic        PC_Changed;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_DATA;
    logic [1:0]  RSP_FAULT;
    logic        LD_CTRL;
    logic [31:0] LD_DATA;
    logic [19:0] LD_ADDR;
    logic        LD_READY;
    logic        STALL;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram_model [int];
    int          loaded [$];

    imem_fetch_unit #(.RAM_LAT(LAT_RAM)) dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .EN                   (EN),
        .REQ_VALID            (REQ_VALID),
        .REQ_READY            (REQ_READY),
        .PC                   (PC),
        .PC_Changed           (PC_Changed),
        .RSP_VALID            (RSP_VALID),
        .RSP_READY            (RSP_READY),
        .RSP_DATA             (RSP_DATA),
        .RSP_FAULT            (RSP_FAULT),
        .TB_LOAD_PROGRAM_CTRL (LD_CTRL),
        .TB_LOAD_PROGRAM_DATA (LD_DATA),
        .TB_LOAD_PROGRAM_ADDR (LD_ADDR),
        .TB_LOAD_READY        (LD_READY),
        .I_FSM_STALL_FETCH    (STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory map: ROM 0x0..0xFFFF, RAM 0x10000..0x40FFFF, misalignment checked first.
    function automatic void model(input logic [31:0] pc, output logic [31:0] data,
                                  output logic [31:0] fault, output int lat);
        lat = 1;
        data = 32'h0;
        if (pc % 4 != 0) begin
            fault = 1;
        end else if (pc < 32'h0001_0000) begin
            fault = 0;
            data = 32'hC0DE_0000 + pc / 4;
        end else if (pc < 32'h0041_0000) begin
            fault = 0;
            lat = LAT_RAM;
            data = ram_model.exists(int'((pc - 32'h0001_0000) / 4)) ?
                   ram_model[int'((pc - 32'h0001_0000) / 4)] : 32'h0;
        end else begin
            fault = 2;
        end
    endfunction

    task automatic fetch(input logic [31:0] pc, input int hold);
        logic [31:0] ed, ef;
        int lat;
        model(pc, ed, ef, lat);
        REQ_VALID = 1'b1;
        PC = pc;
        RSP_READY = 1'b0;
        #1;
        chk("req_ready", 32'(REQ_READY), 1);
        step();
        REQ_VALID = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk("early_valid", 32'(RSP_VALID), 0);
            chk("wait_stall", 32'(STALL), 1);
            step();
        end
        chk("rsp_valid", 32'(RSP_VALID), 1);
        chk("rsp_data", RSP_DATA, ed);
        chk("rsp_fault", 32'(RSP_FAULT), ef);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(RSP_VALID), 1);
            chk("hold_data", RSP_DATA, ed);
            chk("hold_fault", 32'(RSP_FAULT), ef);
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("consumed", 32'(RSP_VALID), 0);
    endtask

    initial begin
        int          idx [8];
        logic [31:0] dat [8];
        logic [31:0] pc;

        RSTn = 1'b0; EN = 1'b1; REQ_VALID = 1'b0; PC = '0; PC_Changed = 1'b0;
        RSP_READY = 1'b0; LD_CTRL = 1'b0; LD_DATA = '0; LD_ADDR = '0;
        step();
        step();
        chk("rst_req_ready", 32'(REQ_READY), 0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_rsp_fault", 32'(RSP_FAULT), 0);
        chk("rst_load_ready", 32'(LD_READY), 0);
        chk("rst_stall", 32'(STALL), 0);
        RSTn = 1'b1;
        #1;
        chk("idle_req_ready", 32'(REQ_READY), 1);

        fetch(32'h0000_0008, 0);

        idx[0] = 3;       dat[0] = 32'hDEAD_BEEF;
        idx[1] = 0;       dat[1] = 32'h1234_5678;
        idx[2] = 'hFFFFF; dat[2] = 32'hFEED_F00D;
        for (int i = 3; i < 8; i++) begin
            idx[i] = int'($urandom_range(4, 1048570));
            dat[i] = $urandom;
        end
        LD_CTRL = 1'b1; LD_ADDR = 20'(idx[0]); LD_DATA = dat[0];
        #1;
        chk("load_ready_idle", 32'(LD_READY), 0);
        chk("req_blocked_by_load", 32'(REQ_READY), 0);
        step();
        for (int i = 0; i < 8; i++) begin
            LD_ADDR = 20'(idx[i]);
            LD_DATA = dat[i];
            #1;
            chk("load_ready", 32'(LD_READY), 1);
            chk("load_stall", 32'(STALL), 1);
            ram_model[idx[i]] = dat[i];
            loaded.push_back(idx[i]);
            step();
        end
        LD_CTRL = 1'b0;
        step();

        fetch(32'h0001_000C, 0);
        chk("deadbeef_model", ram_model[3], 32'hDEAD_BEEF);
        fetch(32'h0000_0006, 0);
        fetch(32'h8000_0000, 0);
        fetch(32'h0000_FFFC, 0);
        fetch(32'h0001_0000, 0);
        fetch(32'h0040_FFFC, 0);
        fetch(32'h0041_0000, 0);
        fetch(32'h0001_000C, 5);

        // Back-to-back: consume response and accept next request in the same cycle.
        REQ_VALID = 1'b1; PC = 32'h0000_0010;
        #1;
        step();
        REQ_VALID = 1'b1; PC = 32'h0000_0014; RSP_READY = 1'b1;
        #1;
        chk("b2b_first_data", RSP_DATA, 32'hC0DE_0004);
        chk("b2b_req_ready", 32'(REQ_READY), 1);
        step();
        REQ_VALID = 1'b0; RSP_READY = 1'b0;
        chk("b2b_valid", 32'(RSP_VALID), 1);
        chk("b2b_data", RSP_DATA, 32'hC0DE_0005);
        EN = 1'b0;
        step();
        chk("en0_valid", 32'(RSP_VALID), 1);
        chk("en0_data", RSP_DATA, 32'hC0DE_0005);
        chk("en0_req_ready", 32'(REQ_READY), 0);
        EN = 1'b1;
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("b2b_consumed", 32'(RSP_VALID), 0);

        // Flush during RAM wait.
        REQ_VALID = 1'b1; PC = 32'h0001_0000;
        #1;
        step();
        REQ_VALID = 1'b0; PC_Changed = 1'b1;
        #1;
        chk("flush_stall", 32'(STALL), 1);
        step();
        PC_Changed = 1'b0;
        RSP_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("flushed_no_rsp", 32'(RSP_VALID), 0);
            step();
        end
        RSP_READY = 1'b0;
        fetch(32'h0001_000C, 1);

        // Reset while waiting on RAM.
        REQ_VALID = 1'b1; PC = 32'h0001_000C;
        #1;
        step();
        REQ_VALID = 1'b0; RSTn = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(REQ_READY), 0);
        step();
        chk("mid_rst_valid", 32'(RSP_VALID), 0);
        chk("mid_rst_data", RSP_DATA, 0);
        chk("mid_rst_fault", 32'(RSP_FAULT), 0);
        chk("mid_rst_stall", 32'(STALL), 0);
        chk("mid_rst_load_ready", 32'(LD_READY), 0);
        RSTn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("no_stale_rsp", 32'(RSP_VALID), 0);
        end
        fetch(32'h0001_000C, 0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: pc = 32'($urandom_range(0, 16383)) << 2;
                1: pc = 32'h0001_0000 + (32'(loaded[$urandom_range(0, loaded.size() - 1)]) << 2);
                2: begin
                    pc = $urandom;
                    if (pc[1:0] == 2'b00) pc[0] = 1'b1;
                end
                default: begin
                    pc = $urandom;
                    pc[31] = 1'b1;
                    pc[1:0] = 2'b00;
                end
            endcase
            fetch(pc, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised instruction-memory front end between the fetch stage and the instruction ROM / RAM.
- Decodes the fetch PC against a configurable ROM window and RAM window, and returns one 32-bit word per request.
- Uses a valid/ready request/response handshake, a configurable RAM read latency, fault reporting, a PC-change flush, and a load port that fills the RAM before the core runs.

Parameters:
ADDR_W, 32, fetch address width in bits
DATA_W, 32, instruction word width in bits
ROM_BASE, 32'h0000_0000, byte base of the ROM window
ROM_AW, 14, ROM word-address width; window size is 4*2^ROM_AW bytes
RAM_BASE, 32'h0001_0000, byte base of the RAM window
RAM_AW, 20, RAM word-address width; window size is 4*2^RAM_AW bytes
RAM_LAT, 1, RAM read latency in cycles, legal range 1..4

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
EN  in  1  global enable; 0 freezes the state machine and counters
REQ_VALID  in  1  fetch request
REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY
PC  in  ADDR_W  byte address of the request
PC_Changed  in  1  flush: squash the outstanding request or held response
RSP_VALID  out  1  response valid
RSP_READY  in  1  consumer accepts the response
RSP_DATA  out  DATA_W  instruction word; 0 when RSP_FAULT != 0
RSP_FAULT  out  2  0 ok, 1 misaligned, 2 unmapped
TB_LOAD_PROGRAM_CTRL  in  1  load-port write strobe
TB_LOAD_PROGRAM_DATA  in  DATA_W  load-port data
TB_LOAD_PROGRAM_ADDR  in  RAM_AW  load-port RAM word address
TB_LOAD_READY  out  1  write performed this cycle when CTRL=1
I_FSM_STALL_FETCH  out  1  request in flight or load active

Behaviour:
- Single clock CLK; reset synchronous on RSTn=0.
- Reset state: IDLE, latency counter 0. Outputs: REQ_READY=0 during reset, RSP_VALID=0, RSP_DATA=0, RSP_FAULT=0, TB_LOAD_READY=0, I_FSM_STALL_FETCH=0.
- Reset asserted mid-operation abandons any request, response or load. No response is produced for it afterwards.
- States: IDLE, ROM_RD, RAM_WAIT, RESP, LOAD.
- IDLE: REQ_READY=EN & !TB_LOAD_PROGRAM_CTRL. On acceptance, latch PC and decode it:
  - PC[1:0]!=0 -> fault 1, go to ROM_RD with data forced to 0.
  - PC inside the ROM window -> ROM_RD, ROM word address (PC-ROM_BASE)>>2.
  - PC inside the RAM window -> RAM_WAIT, counter=RAM_LAT-1, RAM word address (PC-RAM_BASE)>>2.
  - Otherwise -> fault 2, go to ROM_RD with data 0.
  - Window checks use unsigned compares at full ADDR_W. The last word of each window is inside it; base+size is outside.
- ROM_RD: capture ROM data (or the fault), go to RESP. Latency is 1 cycle: RSP_VALID is high in cycle T+1 when accepted in cycle T.
- RAM_WAIT: decrement the counter each EN cycle; at 0, capture RAM data and go to RESP. RSP_VALID is first high in cycle T+RAM_LAT.
- RESP: RSP_VALID=1; RSP_DATA and RSP_FAULT stay stable until RSP_READY.
  - RSP_READY=1 -> IDLE, and REQ_READY=1 in the same cycle (back-to-back fetch allowed).
  - When a new request is accepted in that cycle, the next state comes from its decode.
- PC_Changed=1 in ROM_RD, RAM_WAIT or RESP:
  - Outstanding request dropped, RSP_VALID=0 from the next cycle, go to IDLE.
  - A request presented in the same cycle as PC_Changed is accepted only if the unit is already in IDLE.
- LOAD:
  - Entered from IDLE when TB_LOAD_PROGRAM_CTRL=1; TB_LOAD_READY=1 while in LOAD.
  - Each cycle with CTRL=1 writes DATA to RAM[ADDR].
  - CTRL=0 -> IDLE.
  - CTRL raised while a fetch is in flight: TB_LOAD_READY=0 until the fetch completes or is flushed. The writer must hold its data until TB_LOAD_READY=1.
- I_FSM_STALL_FETCH = state in {ROM_RD, RAM_WAIT, LOAD}.
- EN=0: state, counter and held response freeze; REQ_READY=0; RSP_VALID keeps its value.
- Addresses beyond 2^RAM_AW words are unreachable by construction. The load port has no bounds fault.

Decomposition:
- Package imem_pkg holds:
  - typedef fetch_fault_e (OK=0, MISALIGNED=1, UNMAPPED=2)
  - typedef imem_state_e
  - localparam RAM_LAT_MAX=4
- Sub-module imem_ram_pipe: single-port RAM with a write port and a read pipeline of RAM_LAT registers. The ROM uses the existing rom block.

Test Plan:
- Reset, then REQ_VALID with PC=0x0000_0008 -> accepted cycle T; RSP_VALID at T+1 with RSP_DATA=ROM word 2, RSP_FAULT=0.
- Load 0xDEAD_BEEF at RAM word 3, then fetch PC=0x0001_000C with RAM_LAT=3 -> RSP_VALID first high at T+3, RSP_DATA=0xDEADBEEF, I_FSM_STALL_FETCH high for cycles T+1..T+2.
- Fetch PC=0x0000_0006 -> RSP_FAULT=1, RSP_DATA=0. Fetch PC=0x8000_0000 -> RSP_FAULT=2, RSP_DATA=0. Fetch at the last ROM word and at RAM_BASE -> both OK.
- RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_DATA stable. RSP_READY=1 with REQ_VALID=1 -> next request accepted the same cycle.
- PC_Changed pulse during RAM_WAIT -> no RSP_VALID for the squashed request; the next fetch returns the correct data with normal latency.
- RSTn=0 in RAM_WAIT -> next cycle all outputs at reset values, and no stale response after reset is released.
